// File: rtl/usr_shift_engine.sv
// Multi-step universal shift register: load, clear, shift or rotate one bit per clock.
// Define USR_ROTATE_EN to build ROL/ROR; otherwise opcodes 101/110 behave as NOP.
module usr_shift_engine #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    output logic [WIDTH-1:0] out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ASR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_cnt;
    logic             r_done;

    logic             w_accept;
    logic             w_is_shift_op;
    logic [AW-1:0]    w_amt;
    logic [WIDTH-1:0] w_step;
    logic [0:0]       w_state_d;
    logic [WIDTH-1:0] w_out_d;
    logic [2:0]       w_op_d;
    logic [AW-1:0]    w_cnt_d;
    logic             w_done_d;

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state == S_SHIFT);
    assign out          = r_out;
    assign done         = r_done;
    assign serial_out_l = r_out[WIDTH-1];
    assign serial_out_r = r_out[0];

    assign w_accept = cmd_valid && cmd_ready;
    assign w_amt    = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;

    always_comb begin
        w_is_shift_op = 1'b0;
        case (cmd_op)
            OP_SHL, OP_SHR, OP_ASR: w_is_shift_op = 1'b1;
`ifdef USR_ROTATE_EN
            OP_ROL, OP_ROR:         w_is_shift_op = 1'b1;
`endif
            default:                w_is_shift_op = 1'b0;
        endcase
    end

    // One 1-bit step of the latched op; fill bits are sampled live for streaming.
    always_comb begin
        w_step = r_out;
        case (r_op)
            OP_SHL: w_step = {r_out[WIDTH-2:0], serial_in_l};
            OP_SHR: w_step = {serial_in_r, r_out[WIDTH-1:1]};
            OP_ASR: w_step = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            OP_ROL: w_step = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            OP_ROR: w_step = {r_out[0], r_out[WIDTH-1:1]};
`endif
            default: w_step = r_out;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_out_d   = r_out;
        w_op_d    = r_op;
        w_cnt_d   = r_cnt;
        w_done_d  = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_accept) begin
                if (w_is_shift_op && (w_amt != '0)) begin
                    w_op_d    = cmd_op;
                    w_cnt_d   = w_amt;
                    w_state_d = S_SHIFT;
                end else begin
                    // NOP, LOAD, CLEAR, zero-amount shifts and disabled rotates finish here.
                    w_done_d = 1'b1;
                    if (cmd_op == OP_LOAD) begin
                        w_out_d = load_data;
                    end else if (cmd_op == OP_CLEAR) begin
                        w_out_d = '0;
                    end
                end
            end
        end else begin
            w_out_d = w_step;
            w_cnt_d = r_cnt - AMT_ONE;
            if (r_cnt == AMT_ONE) begin
                w_state_d = S_IDLE;
                w_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_out   <= w_out_d;
            r_op    <= w_op_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_usr_shift_engine.sv
// Scoreboard bench for usr_shift_engine (WIDTH=8): stimulus queues expected results,
// a negedge monitor checks `out` against them whenever `done` pulses.
module tb_usr_shift_engine;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ASR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_amt;
    logic [WIDTH-1:0] load_data;
    logic             serial_in_l;
    logic             serial_in_r;
    logic [WIDTH-1:0] out_w;
    logic             serial_out_l;
    logic             serial_out_r;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb[$];

    usr_shift_engine #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_amt      (cmd_amt),
        .load_data    (load_data),
        .serial_in_l  (serial_in_l),
        .serial_in_r  (serial_in_r),
        .out          (out_w),
        .serial_out_l (serial_out_l),
        .serial_out_r (serial_out_r),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected_done: got done with out 0x%0h, expected none", out_w);
            end else begin
                check("sb_out", {24'd0, out_w}, {24'd0, sb.pop_front()});
                check("sb_serial_out", {30'd0, serial_out_l, serial_out_r},
                      {30'd0, out_w[WIDTH-1], out_w[0]});
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] amt,
                           input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp,
                           input int exp_busy);
        int cyc;
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_amt   = amt;
        load_data = data;
        cmd_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            check("ready_low_while_busy", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("busy_cycles", cyc, exp_busy);
        check("done_high", {31'd0, done}, 32'd1);
        check("out_at_done", {24'd0, out_w}, {24'd0, exp});
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = OP_NOP;
        cmd_amt     = '0;
        load_data   = '0;
        serial_in_l = 1'b0;
        serial_in_r = 1'b0;

        // Asynchronous reset between edges
        #3 reset_n = 1'b0;
        #1;
        check("rst_out", {24'd0, out_w}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(OP_LOAD, 4'd0, 8'hA5, 8'hA5, 0);

        // SHL by 3 with fill 1, checking each step and an ignored command mid-shift
        serial_in_l = 1'b1;
        cmd_op      = OP_SHL;
        cmd_amt     = 4'd3;
        cmd_valid   = 1'b1;
        sb.push_back(8'h2F);
        @(posedge clk); #1;
        check("shl_accept_out", {24'd0, out_w}, 32'hA5);
        check("shl_busy", {31'd0, busy}, 32'd1);
        cmd_op    = OP_LOAD;
        load_data = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("shl_step1", {24'd0, out_w}, 32'h4B);
        @(posedge clk); #1;
        check("shl_step2", {24'd0, out_w}, 32'h97);
        check("shl_busy_step2", {31'd0, busy}, 32'd1);
        check("shl_no_early_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("shl_step3", {24'd0, out_w}, 32'h2F);
        check("shl_idle", {31'd0, busy}, 32'd0);
        check("shl_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        check("shl_done_pulse", {31'd0, done}, 32'd0);
        check("shl_ignored_load", {24'd0, out_w}, 32'h2F);
        serial_in_l = 1'b0;

        run_cmd(OP_LOAD, 4'd0, 8'h90, 8'h90, 0);
        run_cmd(OP_ASR, 4'd2, 8'h00, 8'hE4, 2);
        run_cmd(OP_LOAD, 4'd0, 8'h90, 8'h90, 0);
        serial_in_r = 1'b0;
        run_cmd(OP_SHR, 4'd2, 8'h00, 8'h24, 2);
        run_cmd(OP_LOAD, 4'd0, 8'h90, 8'h90, 0);
        run_cmd(OP_SHR, 4'd0, 8'h00, 8'h90, 0);
        serial_in_r = 1'b1;
        run_cmd(OP_SHR, 4'd3, 8'h00, 8'hF2, 3);
        serial_in_r = 1'b0;

        run_cmd(OP_LOAD, 4'd0, 8'h81, 8'h81, 0);
`ifdef USR_ROTATE_EN
        run_cmd(OP_ROR, 4'd1, 8'h00, 8'hC0, 1);
        run_cmd(OP_LOAD, 4'd0, 8'h81, 8'h81, 0);
        run_cmd(OP_ROL, 4'd12, 8'h00, 8'h81, 8);
`else
        run_cmd(OP_ROR, 4'd1, 8'h00, 8'h81, 0);
        run_cmd(OP_ROL, 4'd12, 8'h00, 8'h81, 0);
`endif

        // Amount above WIDTH clamps to WIDTH
        run_cmd(OP_SHL, 4'd15, 8'h00, 8'h00, 8);
        run_cmd(OP_LOAD, 4'd0, 8'h7E, 8'h7E, 0);
        run_cmd(OP_NOP, 4'd5, 8'hFF, 8'h7E, 0);
        run_cmd(OP_CLEAR, 4'd3, 8'hFF, 8'h00, 0);

        // Reset in the middle of a shift: no completion survives
        run_cmd(OP_LOAD, 4'd0, 8'hFF, 8'hFF, 0);
        cmd_op    = OP_SHL;
        cmd_amt   = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_shift_step2", {24'd0, out_w}, 32'hFC);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out", {24'd0, out_w}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", {22'd0, busy, done, out_w}, 32'h0);
        end
        run_cmd(OP_LOAD, 4'd0, 8'h3C, 8'h3C, 0);

        @(posedge clk); #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usr_shift_engine.md
# usr_shift_engine

Parametrised multi-step universal shift register: accepts one command at a time over a valid/ready handshake and performs parallel load, clear, logical/arithmetic shift or rotate by a programmable amount, one bit position per clock. Successor to the fixed 4-bit shift register. Serves the datapath as a serialiser/deserialiser and barrel-shift substitute where area matters more than latency.

## Interface
- `WIDTH`, default 8: register width; legal range ≥ 2.
- `AW`, localparam = `$clog2(WIDTH+1)`: width of the shift amount.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_op`  in  3  opcode, see Operation.
- `cmd_amt`  in  AW  shift/rotate amount; values above WIDTH clamp to WIDTH.
- `load_data`  in  WIDTH  parallel load value.
- `serial_in_l`  in  1  fill bit entering bit 0 on left shift.
- `serial_in_r`  in  1  fill bit entering bit WIDTH-1 on logical right shift.
- `out`  out  WIDTH  register contents.
- `serial_out_l`  out  1  `out[WIDTH-1]`, combinational from register.
- `serial_out_r`  out  1  `out[0]`, combinational from register.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse on command completion.

## Operation
- Opcodes: 000 NOP; 001 SHL; 010 SHR logical; 011 LOAD; 100 ASR (MSB replicated); 101 ROL; 110 ROR; 111 CLEAR.
- FSM states: IDLE, SHIFT. `cmd_ready = (state == IDLE)`; `busy = (state == SHIFT)`.
- Accept = `cmd_valid && cmd_ready` at a rising edge.
- IDLE, accept of NOP/LOAD/CLEAR, or any shift/rotate with `cmd_amt == 0`: executed at the accept edge (LOAD: `out <= load_data`; CLEAR: `out <= 0`; others: no change). `done` is high the following cycle. FSM stays in IDLE.
- IDLE, accept of shift/rotate with `cmd_amt ≥ 1`: the opcode and clamped amount are latched, `out` is unchanged, and the FSM moves to SHIFT.
- SHIFT: each edge performs one 1-bit step of the latched op and decrements the counter. The edge that performs the final step returns the FSM to IDLE and sets `done` for one cycle.
- Fill bits `serial_in_l`/`serial_in_r` are sampled at each step edge, not at accept, which allows serial streaming.
- `cmd_valid` while busy is ignored; inputs other than serial fill are don't-care during SHIFT.
- A new command may be accepted in the cycle `done` is high.
- Reset (any time, including mid-SHIFT) asynchronously forces IDLE, `out = 0`, counter 0, `done = 0`, `busy = 0`, `cmd_ready = 1`. No command survives reset.

## Timing
- Immediate ops: 1-cycle latency (result and `done` visible after the accept edge).
- Shift/rotate with N = min(`cmd_amt`, WIDTH) ≥ 1: `busy` high N cycles; result and `done` visible after edge N+1 counted from and including the accept edge; `cmd_ready` low N cycles.
- Throughput: one command per N+1 cycles (one per cycle for immediate ops).
- All outputs are registered except `cmd_ready`, `busy`, `serial_out_l` and `serial_out_r`, which decode directly from registers.

## Configuration
- `USR_ROTATE_EN` defined: ROL/ROR operate as described.
- `USR_ROTATE_EN` undefined: opcodes 101/110 are treated as NOP. They are accepted, complete immediately with a `done` pulse, and leave `out` unchanged. No rotate logic is synthesised.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive `reset_n` low between clock edges → `out=0x00`, `busy=0`, `done=0`, `cmd_ready=1` immediately, without waiting for `clk`.
- LOAD 0xA5 → `out=0xA5` after the accept edge; `done` high exactly 1 cycle; `busy` never asserted.
- From 0xA5, SHL amt=3, `serial_in_l=1` → 0x4B, 0x97, 0x2F on successive steps; `busy` 3 cycles; `done` with final 0x2F; a `cmd_valid` pulse during busy is not accepted.
- From 0x90, ASR amt=2 → 0xE4. From 0x90, SHR amt=2 with `serial_in_r=0` → 0x24. From 0x90, SHR amt=0 → 0x90 with 1-cycle `done`.
- With `USR_ROTATE_EN`, from 0x81: ROR amt=1 → 0xC0; ROL amt=12 (clamped to 8) → 0x81 after 8 busy cycles. Without the macro: ROR amt=1 → 0x81 unchanged, 1-cycle `done`.
- From 0xFF, start SHL amt=5 and assert `reset_n` low after step 2 → `out=0x00`, IDLE, no `done`. After release, LOAD 0x3C is accepted and completes normally.
